// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit period and
// parity-mode constants. The receiver uses this package too.
package uart_pkg;

  // 50 MHz system clock at 115200 baud
  localparam int CLK_DIV_DEFAULT = 434;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Parity over one byte; odd mode inverts the plain XOR
  function automatic logic parity_of(input logic [7:0] data, input logic mode);
    return (^data) ^ mode;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: while en is high, tick pulses on the last cycle of every
// CLK_DIV-cycle period. Dropping en restarts the period from the top.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

  logic [15:0] cnt;

  // Down-counter from CLK_DIV-1 to 0, reloaded at zero or while disabled
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= RELOAD;
    end else if (cnt == 16'd0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

  assign tick = en && (cnt == 16'd0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register in front of a start/data/
// parity/stop serializer. A byte held while a frame is on the line starts
// on the cycle right after the final stop cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam logic       PAR_MODE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_t state;
  logic [7:0]  hold_data;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        hold_full;
  logic        up;
  logic        par;
  logic        txd;
  logic        tick;
  logic        accept;
  logic        stop_end;
  logic        load;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) baud (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );

  // ready is held low through reset and rises the cycle after it releases
  assign tx_ready = up && !hold_full;
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state != IDLE) || hold_full;
  assign uart_txd = txd;

  // Last cycle of the last stop bit
  assign stop_end = (state == STOP) && tick && (bit_cnt == LAST_STOP);
  assign tx_done  = stop_end;

  // Move the held byte into the serializer: from idle, or straight out of stop
  assign load = hold_full && ((state == IDLE) || stop_end);

  // Frame sequencer, holding register and registered line driver
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      txd       <= 1'b1;
      hold_full <= 1'b0;
      up        <= 1'b0;
      bit_cnt   <= 3'd0;
    end else begin
      up <= 1'b1;

      // tx_ready is low whenever the register is full, so an accept can
      // never collide with the transfer below
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: ;
        START: begin
          if (tick) begin
            state   <= DATA;
            txd     <= shift[0];
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == 3'd7) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                txd   <= par;
              end else begin
                state <= STOP;
                txd   <= 1'b1;
              end
              bit_cnt <= 3'd0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              txd     <= shift[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state   <= STOP;
            txd     <= 1'b1;
            bit_cnt <= 3'd0;
          end
        end
        STOP: begin
          if (tick) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              bit_cnt <= 3'd0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase

      // Start bit goes out on the same edge the byte leaves the holding register
      if (load) begin
        state     <= START;
        txd       <= 1'b0;
        shift     <= hold_data;
        par       <= parity_of(hold_data, PAR_MODE);
        hold_full <= 1'b0;
      end
    end
  end

endmodule
